// File: rtl/wide_ram_read_seq_pkg.sv
// Shared definitions for the wide sample RAM read path.
// Latency lives here so the RAM wrapper and sequencer agree.
package wide_ram_read_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int READ_LATENCY_DEF = 6;

endpackage

// File: rtl/wide_ram_read_seq_if.sv
// Command and read-port bundle of the wide RAM read sequencer.
// master issues commands; slave is the sequencer.
interface wide_ram_read_seq_if #(
    parameter int ADDRWIDTHB = 10,
    parameter int LENWIDTH   = 11
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDRWIDTHB-1:0] cmd_start;
    logic [LENWIDTH-1:0]   cmd_len;
    logic                  cmd_loop;
    logic                  abort;
    logic [ADDRWIDTHB-1:0] addrB;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  busy;
    logic                  done;
    logic                  aborted;

    modport master (
        output cmd_valid, cmd_start, cmd_len, cmd_loop, abort,
        input  cmd_ready, addrB, rd_valid, rd_last,
        input  busy, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_len, cmd_loop, abort,
        output cmd_ready, addrB, rd_valid, rd_last,
        output busy, done, aborted
    );
endinterface

// File: rtl/wide_ram_read_seq_delay.sv
// {valid,last} shift register matching the RAM read pipeline.
// Tokens enter in the cycle their address is on addrB.
module valid_delay_line #(
    parameter int DEPTH = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o,
    output logic last_nxt_o,
    output logic empty_o
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] lst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], valid_i};
            lst_q <= {lst_q[DEPTH-2:0], valid_i & last_i};
        end
    end

    assign valid_o    = vld_q[DEPTH-1];
    assign last_o     = lst_q[DEPTH-1];
    // last token reaches the output on the next edge
    assign last_nxt_o = lst_q[DEPTH-2];
    // nothing queued behind the output stage
    assign empty_o    = ~|vld_q[DEPTH-2:0];
endmodule

// File: rtl/wide_ram_read_seq.sv
// Read-side sequencer: walks the wide read address and
// tags the RAM's registered read data with valid/last.
module wide_ram_read_seq
    import wide_ram_read_pkg::*;
#(
    parameter int ADDRWIDTHB   = 10,
    parameter int LENWIDTH     = 11,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input logic              clk,
    input logic              rst,
    wide_ram_read_seq_if.slave bus
);
    rd_state_e             state_q;
    logic [ADDRWIDTHB-1:0] start_q;
    logic [LENWIDTH-1:0]   len_q;
    logic                  loop_q;
    logic [LENWIDTH-1:0]   idx_q;
    logic [ADDRWIDTHB-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  aborted_q;
    logic                  ready_q;

    logic                  issue;
    logic                  at_last;
    logic                  flush;
    logic [LENWIDTH-1:0]   idx_d;
    logic [ADDRWIDTHB-1:0] addr_d;
    logic                  dl_valid;
    logic                  dl_last;
    logic                  dl_last_nxt;
    logic                  dl_empty;

    assign issue   = (state_q == ISSUE);
    assign at_last = (idx_q == len_q - 1'b1);
    assign flush   = bus.abort && (state_q != IDLE);
    assign idx_d   = idx_q + 1'b1;
    assign addr_d  = start_q + ADDRWIDTHB'(idx_d);

    valid_delay_line #(
        .DEPTH(READ_LATENCY)
    ) u_dl (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .valid_i   (issue),
        .last_i    (at_last),
        .valid_o   (dl_valid),
        .last_o    (dl_last),
        .last_nxt_o(dl_last_nxt),
        .empty_o   (dl_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (bus.cmd_len != '0) begin
                            start_q <= bus.cmd_start;
                            len_q   <= bus.cmd_len;
                            loop_q  <= bus.cmd_loop;
                            idx_q   <= '0;
                            addr_q  <= bus.cmd_start;
                            busy_q  <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else if (at_last) begin
                        if (loop_q) begin
                            idx_q  <= '0;
                            addr_q <= start_q;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        idx_q  <= idx_d;
                        addr_q <= addr_d;
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        // done lines up with the final rd_last
                        if (dl_last_nxt) done_q <= 1'b1;
                        if (dl_empty) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.addrB     = addr_q;
    assign bus.rd_valid  = dl_valid;
    assign bus.rd_last   = dl_last;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_wide_ram_read_seq.sv
// Scoreboard bench for wide_ram_read_seq.
// Expected addrB/rd/done/aborted cycles are queued at command time.
module tb_wide_ram_read_seq;
    localparam int LAT = 6;

    typedef struct {
        int         cyc;
        logic [9:0] a;
    } addr_e_t;

    typedef struct {
        int   cyc;
        logic last;
    } rd_e_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tb_cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    addr_e_t exp_addr[$];
    rd_e_t   exp_rd[$];
    int      exp_done[$];
    int      exp_ab[$];

    wide_ram_read_seq_if #(.ADDRWIDTHB(10), .LENWIDTH(11)) bus ();

    wide_ram_read_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, act, exp, tb_cyc);
        end
    endtask

    addr_e_t ma;
    rd_e_t   mr;
    int      mi;

    always @(negedge clk) begin
        if (exp_addr.size() != 0 && exp_addr[0].cyc <= tb_cyc) begin
            ma = exp_addr.pop_front();
            chk("addrB_cyc", tb_cyc, ma.cyc);
            chk("addrB", bus.addrB, ma.a);
        end
        if (bus.rd_valid) begin
            if (exp_rd.size() == 0) chk("rd_valid_unexp", 1, 0);
            else begin
                mr = exp_rd.pop_front();
                chk("rd_cyc", tb_cyc, mr.cyc);
                chk("rd_last", bus.rd_last, mr.last);
            end
        end else if (exp_rd.size() != 0 && exp_rd[0].cyc <= tb_cyc) begin
            mr = exp_rd.pop_front();
            chk("rd_valid_miss", 0, 1);
        end else if (bus.rd_last) begin
            chk("rd_last_alone", 1, 0);
        end
        if (bus.done) begin
            if (exp_done.size() == 0) chk("done_unexp", 1, 0);
            else begin
                mi = exp_done.pop_front();
                chk("done_cyc", tb_cyc, mi);
            end
        end else if (exp_done.size() != 0 && exp_done[0] <= tb_cyc) begin
            mi = exp_done.pop_front();
            chk("done_miss", 0, 1);
        end
        if (bus.aborted) begin
            if (exp_ab.size() == 0) chk("aborted_unexp", 1, 0);
            else begin
                mi = exp_ab.pop_front();
                chk("aborted_cyc", tb_cyc, mi);
            end
        end else if (exp_ab.size() != 0 && exp_ab[0] <= tb_cyc) begin
            mi = exp_ab.pop_front();
            chk("aborted_miss", 0, 1);
        end
    end

    // ev_off: cycle offset of abort/reset after accept, -1 for none
    task automatic send(input logic [9:0] st, input logic [10:0] ln,
                        input logic lp, input int ev_off,
                        input logic use_rst, input logic idle_ab,
                        output int t);
        int lim;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("cmd_ready_timeout", 0, 1);
        t = tb_cyc;
        bus.cmd_valid = 1'b1;
        bus.cmd_start = st;
        bus.cmd_len   = ln;
        bus.cmd_loop  = lp;
        bus.abort     = idle_ab;
        lim = (ev_off >= 0) ? t + ev_off : 32'h7fff_ffff;
        for (int k = 0; t + 1 + k <= lim; k++) begin
            if (ln == 0) break;
            if (!lp && k >= int'(ln)) break;
            exp_addr.push_back('{t + 1 + k, st + 10'(k % int'(ln))});
            if (t + 1 + k + LAT <= lim)
                exp_rd.push_back('{t + 1 + k + LAT,
                                   (k % int'(ln)) == int'(ln) - 1});
        end
        if (ev_off < 0)
            exp_done.push_back(ln == 0 ? t + 1 : t + int'(ln) + LAT);
        else if (!use_rst)
            exp_ab.push_back(lim + 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        if (ev_off >= 0) begin
            while (tb_cyc < lim) @(negedge clk);
            if (use_rst) rst = 1'b1;
            else bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            chk("rd_valid_after_ev", bus.rd_valid, 0);
            if (use_rst) begin
                chk("rst_addrB", bus.addrB, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_ready", bus.cmd_ready, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_aborted", bus.aborted, 0);
                chk("rst_last", bus.rd_last, 0);
                rst = 1'b0;
                @(negedge clk);
                chk("ready_after_rst", bus.cmd_ready, 1);
            end else begin
                chk("ready_after_abort", bus.cmd_ready, 1);
                chk("busy_after_abort", bus.busy, 0);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_rd.size() != 0 ||
                exp_done.size() != 0 || exp_ab.size() != 0 ||
                bus.busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_start = '0;
        bus.cmd_len   = '0;
        bus.cmd_loop  = 1'b0;
        bus.abort     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.cmd_ready, 0);
        chk("reset_addrB", bus.addrB, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rd_valid", bus.rd_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_reset", bus.cmd_ready, 1);

        // basic pass with busy/ready timing
        send(10'h010, 11'd4, 1'b0, -1, 1'b0, 1'b0, t);
        chk("busy_first", bus.busy, 1);
        chk("ready_low", bus.cmd_ready, 0);
        while (tb_cyc < t + 4 + LAT) @(negedge clk);
        chk("busy_end", bus.busy, 1);
        chk("ready_end", bus.cmd_ready, 0);
        @(negedge clk);
        chk("busy_clear", bus.busy, 0);
        chk("ready_back", bus.cmd_ready, 1);
        wait_idle();

        // wrap past top of RAM
        send(10'h3FE, 11'd4, 1'b0, -1, 1'b0, 1'b0, t);
        wait_idle();

        // zero length
        send(10'h155, 11'd0, 1'b0, -1, 1'b0, 1'b0, t);
        chk("len0_addrB", bus.addrB, 10'h001);
        chk("len0_busy", bus.busy, 0);
        chk("len0_ready", bus.cmd_ready, 0);
        @(negedge clk);
        chk("len0_ready_back", bus.cmd_ready, 1);
        wait_idle();

        // loop then abort before the first pass's last word
        send(10'h020, 11'd3, 1'b1, 8, 1'b0, 1'b0, t);
        wait_idle();

        // loop over several passes, then abort
        send(10'h3FF, 11'd2, 1'b1, 15, 1'b0, 1'b0, t);
        wait_idle();

        // reset in the middle of a command
        send(10'h100, 11'd8, 1'b0, 5, 1'b1, 1'b0, t);
        send(10'h3FF, 11'd2, 1'b0, -1, 1'b0, 1'b0, t);
        wait_idle();

        // abort while idle alongside a command
        send(10'h040, 11'd3, 1'b0, -1, 1'b0, 1'b1, t);
        wait_idle();

        // abort while draining
        send(10'h200, 11'd2, 1'b0, 5, 1'b0, 1'b0, t);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            send(10'($urandom_range(0, 1023)),
                 11'($urandom_range(1, 9)), 1'b0, -1, 1'b0, 1'b0, t);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
